ex_stage_muldiv: RTL
====================

EX_STAGE_MULDIV -- requirements
Module: ex_stage_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on posedge clk.
REQ-004 SHALL have port in_valid, input, 1, ID/EX register holds a live instruction.
REQ-005 SHALL have port in_EX, input, 5, control field: [4] RegDst, [3:1] ALUOp, [0] ALUSrc.
REQ-006 SHALL have ports in_Dato1 and in_Dato2, input, 32 each, register-file operands rs and rt.
REQ-007 SHALL have port in_Extend, input, 32, sign-extended immediate; [5:0] is the funct field for R-type.
REQ-008 SHALL have ports in_b20_16 and in_b15_11, input, 5 each, rt and rd destination candidates.
REQ-009 SHALL have port ou_ALURes, output, 32, registered result.
REQ-010 SHALL have port ou_Dato2, output, 32, registered rt data for stores.
REQ-011 SHALL have port ou_WReg, output, 5, registered destination register.
REQ-012 SHALL have port ou_Zero, output, 1, registered; equals (ou_ALURes == 0).
REQ-013 SHALL have port ou_valid, output, 1, registered EX/MEM entry is live.
REQ-014 SHALL have port ou_stall, output, 1; upstream holds ID/EX contents while it is high.

Function
REQ-015 SHALL select operand B as in_Extend when ALUSrc=1, else in_Dato2; ou_WReg SHALL be in_b15_11 when RegDst=1, else in_b20_16.
REQ-016 SHALL decode ALUOp as: 000 add, 001 sub, 010 R-type by funct, 011 and, 100 or, 101 slt (signed); 110 and 111 yield result 0.
REQ-017 SHALL decode funct as: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x10 mfhi, 0x12 mflo, 0x19 multu, 0x1B divu; any other funct yields result 0.
REQ-018 SHALL wrap add/sub modulo 2^32 with no overflow trap.
REQ-019 SHALL have an FSM with states IDLE and BUSY plus a 5-bit iteration counter.
REQ-020 In IDLE with in_valid=1 and a single-cycle op, SHALL register the result, rt data, ou_WReg and ou_valid=1 at the next edge (latency 1).
REQ-021 In IDLE with in_valid=0, SHALL register ou_valid=0 at the next edge; the other outputs are don't-care.
REQ-022 In IDLE with in_valid=1 and multu/divu, SHALL latch both operands, load counter=31, enter BUSY, and register ou_valid=0.
REQ-023 In BUSY, SHALL perform one shift-add (multu) or one restoring shift-subtract (divu) step per cycle and decrement the counter.
REQ-024 At the BUSY edge with counter=0, SHALL write HI/LO and return to IDLE. multu: HI=product[63:32], LO=product[31:0]. divu: LO=quotient, HI=remainder.
REQ-025 divu with divisor 0 SHALL give LO=0xFFFFFFFF and HI=dividend.
REQ-026 ou_stall SHALL equal (state==BUSY), exactly 32 cycles after the accepting edge; in_* SHALL be ignored while BUSY and ou_valid SHALL be 0.
REQ-027 mfhi/mflo accepted in IDLE SHALL return the HI/LO value present at that edge, including a value written at the immediately preceding edge.

Reset
REQ-028 With rst_n=0 at a posedge, SHALL set state=IDLE, counter=0, HI=LO=0, all ou_* registers=0 and ou_stall=0.
REQ-029 Reset during BUSY SHALL abort the operation and leave HI/LO=0; reset SHALL have priority over every other event.

Structure
REQ-030 SHALL place ALUOp codes, funct constants and the state encoding in the shared package mips_pkg.
REQ-031 SHALL implement the iterative multiply/divide engine as one sub-module, muldiv_iter, with start, op, operand, busy, done, hi and lo signals.

Verification
REQ-032 ALU: in_valid=1, ALUOp=010, funct=0x22, Dato1=5, Dato2=7 -> next cycle ou_ALURes=0xFFFFFFFE, ou_Zero=0, ou_valid=1.
REQ-033 Immediate: ALUSrc=1, ALUOp=000, Dato1=0x10, Extend=0xFFFFFFFC, RegDst=0, b20_16=9 -> ou_ALURes=0xC, ou_WReg=9.
REQ-034 Multiply: multu of 0xFFFFFFFF by 2 -> ou_stall high for exactly 32 cycles; then an mfhi held upstream returns 1 and mflo returns 0xFFFFFFFE.
REQ-035 Divide by zero: divu of 100 by 0 -> after the stall, mfhi returns 100 and mflo returns 0xFFFFFFFF; divu of 100 by 7 -> LO=14, HI=2.
REQ-036 Reset mid-operation: rst_n=0 on BUSY cycle 10 -> next cycle ou_stall=0, ou_valid=0, and mfhi returns 0.
REQ-037 Back-to-back: sub 3-3, then slt -1<1, then add -> ou_Zero=1, then ou_ALURes=1, with ou_valid continuously 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared EX-stage constants: ALUOp codes, R-type funct values, FSM encoding.
package mips_pkg;

    localparam int XLEN = 32;

    // ALUOp field of the EX control word
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // R-type funct field
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // Multi-cycle engine state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef enum logic {
        MD_MULTU = 1'b0,
        MD_DIVU  = 1'b1
    } md_op_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// Owns the HI/LO architectural registers.
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [0:0]       state;
    logic [4:0]       cnt;
    md_op_e           op_q;
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor
    // acc[2W:W] partial product / remainder, acc[W-1:0] multiplier / quotient
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_nxt;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   rsh;

    assign busy = (state == ST_BUSY);
    assign done = busy && (cnt == 5'd0);

    // One iteration step. Divisor 0 needs no special case: every trial
    // subtract succeeds, so quotient becomes all ones and the remainder
    // collects the whole dividend.
    always_comb begin
        msum    = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
        rsh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        acc_nxt = acc;
        if (op_q == MD_MULTU) begin
            acc_nxt = {1'b0, msum, acc[WIDTH-1:1]};
        end else if (rsh >= {1'b0, opnd}) begin
            acc_nxt = {rsh - {1'b0, opnd}, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {rsh, acc[WIDTH-2:0], 1'b0};
        end
    end

    // FSM, counter, datapath and HI/LO update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            op_q  <= MD_MULTU;
            opnd  <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_BUSY;
                        cnt   <= 5'(WIDTH - 1);
                        op_q  <= op;
                        opnd  <= op_b;
                        acc   <= {{(WIDTH+1){1'b0}}, op_a};
                    end
                end
                default: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= ST_IDLE;
                        hi    <= acc_nxt[2*WIDTH-1:WIDTH];
                        lo    <= acc_nxt[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_muldiv.sv
// MIPS EX stage: single-cycle ALU plus iterative multu/divu with HI/LO,
// registering the EX/MEM pipeline fields.
module ex_stage_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [4:0]       in_EX,
    input  logic [WIDTH-1:0] in_Dato1,
    input  logic [WIDTH-1:0] in_Dato2,
    input  logic [WIDTH-1:0] in_Extend,
    input  logic [4:0]       in_b20_16,
    input  logic [4:0]       in_b15_11,
    output logic [WIDTH-1:0] ou_ALURes,
    output logic [WIDTH-1:0] ou_Dato2,
    output logic [4:0]       ou_WReg,
    output logic             ou_Zero,
    output logic             ou_valid,
    output logic             ou_stall
);

    logic             reg_dst;
    logic [2:0]       alu_op;
    logic             alu_src;
    logic [5:0]       funct;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             is_md;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    md_op_e           md_op;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    assign reg_dst = in_EX[4];
    assign alu_op  = in_EX[3:1];
    assign alu_src = in_EX[0];
    assign funct   = in_Extend[5:0];
    assign opb     = alu_src ? in_Extend : in_Dato2;

    assign is_md    = (alu_op == ALUOP_RTYPE) &&
                      ((funct == FN_MULTU) || (funct == FN_DIVU));
    assign md_op    = (funct == FN_DIVU) ? MD_DIVU : MD_MULTU;
    assign md_start = in_valid && is_md && !md_busy;
    assign ou_stall = md_busy;

    // Single-cycle result; HI/LO are read straight from the engine so a
    // value written on the previous edge is already visible here.
    always_comb begin
        res = '0;
        case (alu_op)
            ALUOP_ADD: res = in_Dato1 + opb;
            ALUOP_SUB: res = in_Dato1 - opb;
            ALUOP_AND: res = in_Dato1 & opb;
            ALUOP_OR:  res = in_Dato1 | opb;
            ALUOP_SLT: res = ($signed(in_Dato1) < $signed(opb)) ? WIDTH'(1) : '0;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  res = in_Dato1 + opb;
                    FN_SUB:  res = in_Dato1 - opb;
                    FN_AND:  res = in_Dato1 & opb;
                    FN_OR:   res = in_Dato1 | opb;
                    FN_SLT:  res = ($signed(in_Dato1) < $signed(opb)) ? WIDTH'(1) : '0;
                    FN_MFHI: res = hi;
                    FN_MFLO: res = lo;
                    default: res = '0;
                endcase
            end
            default: res = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (md_op),
        .op_a  (in_Dato1),
        .op_b  (in_Dato2),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (hi),
        .lo    (lo)
    );

    // EX/MEM register: frozen-invalid while the engine runs, and an
    // accepted multu/divu produces no writeback entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ou_ALURes <= '0;
            ou_Dato2  <= '0;
            ou_WReg   <= '0;
            ou_Zero   <= 1'b0;
            ou_valid  <= 1'b0;
        end else if (md_busy) begin
            ou_valid  <= 1'b0;
        end else begin
            ou_ALURes <= res;
            ou_Dato2  <= in_Dato2;
            ou_WReg   <= reg_dst ? in_b15_11 : in_b20_16;
            ou_Zero   <= (res == '0);
            ou_valid  <= in_valid && !is_md;
        end
    end

endmodule
